mem_responder: RTL and testbench

//  Memory-side responder for the control unit's mem_rd/mem_wr strobes. Accepts one word read or

---
 rtl/mem_responder.sv | 154 +++++++++++++++
 tb/tb_mem_responder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: word RAM that answers mem_rd/mem_wr strobes after a fixed
// number of wait states. It raises a one-cycle mem_ready (with mem_err on
// failure) once the access is done.
// Optional build macro MEM_BOUNDS_CHECK_EN: addresses >= DEPTH are rejected
// with mem_err. Without it, the address wraps modulo DEPTH.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting for a strobe; addr/data/op are latched on acceptance
// ST_WAIT | counting down the wait states
// ST_DONE | performing the access; outputs and ready are updated at its edge
module mem_responder #(
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH       = 1024,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mem_rd,
   input  logic                  mem_wr,
   input  logic [31:0]           addr,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_oe,
   output logic                  mem_ready,
   output logic                  mem_err
);

   localparam int         IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [31:0]           addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  op_rd_q, op_rd_d;
   logic                  op_wr_q, op_wr_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  oe_q, oe_d;
   logic                  rdy_q, rdy_d;
   logic                  err_q, err_d;

   logic [DATA_WIDTH-1:0] ram [DEPTH];
   logic                  ram_we;
   logic [IDX_W-1:0]      idx;
   logic                  range_err;

   assign idx = addr_q[IDX_W-1:0];

`ifdef MEM_BOUNDS_CHECK_EN
   assign range_err = (addr_q[31:IDX_W] != '0);
`else
   // Upper address bits are deliberately ignored so the RAM aliases modulo DEPTH.
   logic unused_addr_hi;
   assign unused_addr_hi = ^addr_q[31:IDX_W];
   assign range_err      = 1'b0;
`endif

   // Next-state, latching and output decisions.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      op_rd_d = op_rd_q;
      op_wr_d = op_wr_q;
      dout_d  = dout_q;
      oe_d    = oe_q;
      rdy_d   = 1'b0;
      err_d   = 1'b0;
      ram_we  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (mem_rd || mem_wr) begin
               addr_d  = addr;
               wdata_d = data_in;
               op_rd_d = mem_rd;
               op_wr_d = mem_wr;
               cnt_d   = WAIT_LD;
               oe_d    = 1'b0;
               state_d = (WAIT_LD == 4'd0) ? ST_DONE : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q <= 4'd1) begin
               cnt_d   = 4'd0;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_DONE: begin
            rdy_d   = 1'b1;
            state_d = ST_IDLE;
            if (op_rd_q && op_wr_q) begin
               err_d = 1'b1;
            end else if (range_err) begin
               err_d = 1'b1;
               if (op_rd_q) begin
                  dout_d = '0;
               end
            end else if (op_rd_q) begin
               dout_d = ram[idx];
               oe_d   = 1'b1;
            end else begin
               ram_we = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers; reset abandons any transaction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         op_rd_q <= 1'b0;
         op_wr_q <= 1'b0;
         dout_q  <= '0;
         oe_q    <= 1'b0;
         rdy_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         op_rd_q <= op_rd_d;
         op_wr_q <= op_wr_d;
         dout_q  <= dout_d;
         oe_q    <= oe_d;
         rdy_q   <= rdy_d;
         err_q   <= err_d;
      end
   end

   // RAM write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         ram[idx] <= wdata_q;
      end
   end

   assign data_out  = dout_q;
   assign data_oe   = oe_q;
   assign mem_ready = rdy_q;
   assign mem_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder. dut1 uses one wait state and dut0 uses
// none; both share the clock and reset.
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        rd1 = 1'b0, wr1 = 1'b0;
   logic [31:0] addr1 = '0, din1 = '0;
   logic [31:0] dout1;
   logic        oe1, rdy1, err1;

   logic        rd0 = 1'b0, wr0 = 1'b0;
   logic [31:0] addr0 = '0, din0 = '0;
   logic [31:0] dout0;
   logic        oe0, rdy0, err0;

   int n_checks = 0;
   int n_fail   = 0;

   int          r_lat;
   logic        r_err, r_oe;
   logic [31:0] r_dout;

   always #5 clk = ~clk;

   mem_responder #(.DATA_WIDTH(32), .DEPTH(1024), .WAIT_CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .mem_rd(rd1), .mem_wr(wr1), .addr(addr1),
      .data_in(din1), .data_out(dout1), .data_oe(oe1), .mem_ready(rdy1), .mem_err(err1)
   );

   mem_responder #(.DATA_WIDTH(32), .DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .mem_rd(rd0), .mem_wr(wr0), .addr(addr0),
      .data_in(din0), .data_out(dout0), .data_oe(oe0), .mem_ready(rdy0), .mem_err(err0)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input bit sel, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d);
      if (sel) begin rd1 = rd; wr1 = wr; addr1 = a; din1 = d; end
      else     begin rd0 = rd; wr0 = wr; addr0 = a; din0 = d; end
   endtask

   function automatic logic get_rdy(input bit sel);
      return sel ? rdy1 : rdy0;
   endfunction

   // One transaction; ready must rise 1+WAIT_CYCLES edges after acceptance.
   task automatic txn(input string tag, input bit sel, input logic rd, input logic wr,
                      input logic [31:0] a, input logic [31:0] d, input bit chg);
      bit got;
      @(negedge clk);
      drive(sel, rd, wr, a, d);
      @(posedge clk); #1;
      check({tag, "_oe_clr"}, sel ? oe1 : oe0, 1'b0);
      if (chg) drive(sel, rd, wr, a ^ 32'h1, ~d);
      r_lat = 0;
      got   = 1'b0;
      while (!got && r_lat < 20) begin
         @(posedge clk); #1;
         r_lat++;
         if (get_rdy(sel)) got = 1'b1;
      end
      check({tag, "_ready_seen"}, got, 1'b1);
      r_err  = sel ? err1 : err0;
      r_oe   = sel ? oe1 : oe0;
      r_dout = sel ? dout1 : dout0;
      drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
      check({tag, "_lat"}, r_lat, sel ? 2 : 1);
      @(posedge clk); #1;
      check({tag, "_ready_pulse"}, get_rdy(sel), 1'b0);
   endtask

   task automatic expect_rsp(input string tag, input logic err, input logic [31:0] dout,
                             input logic oe);
      check({tag, "_err"}, r_err, err);
      check({tag, "_dout"}, r_dout, dout);
      check({tag, "_oe"}, r_oe, oe);
   endtask

   initial begin
      int t_first, t_second, n_seen;
      logic [31:0] d_first, d_second;
      bit bounds;
`ifdef MEM_BOUNDS_CHECK_EN
      bounds = 1'b1;
`else
      bounds = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      check("rst_dout", dout1, 32'h0);
      check("rst_oe", oe1, 1'b0);
      check("rst_ready", rdy1, 1'b0);
      check("rst_err", err1, 1'b0);
      @(negedge clk) rst_n = 1'b1;

      // Interrupted write must not commit and reset clears the outputs.
      txn("w10", 1, 0, 1, 32'h10, 32'h1111_1111, 0);
      expect_rsp("w10", 0, 32'h0, 0);
      txn("r10a", 1, 1, 0, 32'h10, 32'h0, 0);
      expect_rsp("r10a", 0, 32'h1111_1111, 1);
      @(negedge clk);
      drive(1, 0, 1, 32'h10, 32'h2222_2222);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("midrst_dout", dout1, 32'h0);
      check("midrst_oe", oe1, 1'b0);
      check("midrst_ready", rdy1, 1'b0);
      check("midrst_err", err1, 1'b0);
      drive(1, 0, 0, 32'h0, 32'h0);
      repeat (2) begin
         @(posedge clk); #1;
         check("midrst_no_ready", rdy1, 1'b0);
      end
      @(negedge clk) rst_n = 1'b1;
      txn("r10b", 1, 1, 0, 32'h10, 32'h0, 0);
      expect_rsp("r10b", 0, 32'h1111_1111, 1);

      // data_oe holds while idle after a read.
      repeat (3) begin
         @(posedge clk); #1;
         check("oe_hold", oe1, 1'b1);
      end

      // Write then read back; a write leaves data_out untouched.
      txn("w5", 1, 0, 1, 32'h5, 32'hDEAD_BEEF, 0);
      expect_rsp("w5", 0, 32'h1111_1111, 0);
      txn("r5", 1, 1, 0, 32'h5, 32'h0, 0);
      expect_rsp("r5", 0, 32'hDEAD_BEEF, 1);

      // Illegal op: error with ready, no RAM access.
      txn("w7", 1, 0, 1, 32'h7, 32'h77, 0);
      txn("r7a", 1, 1, 0, 32'h7, 32'h0, 0);
      expect_rsp("r7a", 0, 32'h77, 1);
      txn("ill7", 1, 1, 1, 32'h7, 32'h99, 0);
      expect_rsp("ill7", 1, 32'h77, 0);
      txn("r7b", 1, 1, 0, 32'h7, 32'h0, 0);
      expect_rsp("r7b", 0, 32'h77, 1);

      // Address beyond DEPTH: wraps by default, error when bounds checking is built in.
      txn("w3", 1, 0, 1, 32'h3, 32'h33, 0);
      txn("w403", 1, 0, 1, 32'h403, 32'hA5, 0);
      expect_rsp("w403", bounds, 32'h77, 0);
      txn("r3", 1, 1, 0, 32'h3, 32'h0, 0);
      expect_rsp("r3", 0, bounds ? 32'h33 : 32'hA5, 1);
      txn("r403", 1, 1, 0, 32'h403, 32'h0, 0);
      if (bounds) expect_rsp("r403", 1, 32'h0, 0);
      else        expect_rsp("r403", 0, 32'hA5, 1);

      // Inputs changed during WAIT are ignored.
      txn("w21", 1, 0, 1, 32'h21, 32'hCAFE, 0);
      txn("w20chg", 1, 0, 1, 32'h20, 32'h1234_5678, 1);
      txn("r21", 1, 1, 0, 32'h21, 32'h0, 0);
      expect_rsp("r21", 0, 32'hCAFE, 1);
      txn("r20chg", 1, 1, 0, 32'h20, 32'h0, 1);
      expect_rsp("r20chg", 0, 32'h1234_5678, 1);

      // Zero wait states, back-to-back reads with the strobe held through ready.
      txn("z_w1", 0, 0, 1, 32'h1, 32'h0000_0101, 0);
      txn("z_w2", 0, 0, 1, 32'h2, 32'h0000_0202, 0);
      @(negedge clk);
      drive(0, 1, 0, 32'h1, 32'h0);
      @(posedge clk); #1;
      addr0 = 32'h2;
      t_first = 0; t_second = 0; n_seen = 0;
      d_first = '0; d_second = '0;
      for (int e = 1; e <= 8; e++) begin
         @(posedge clk); #1;
         if (rdy0) begin
            n_seen++;
            if (n_seen == 1) begin t_first = e; d_first = dout0; end
            if (n_seen == 2) begin t_second = e; d_second = dout0; rd0 = 1'b0; end
         end
      end
      check("b2b_count", n_seen, 2);
      check("b2b_first_edge", t_first, 1);
      check("b2b_spacing", t_second - t_first, 2);
      check("b2b_data1", d_first, 32'h0000_0101);
      check("b2b_data2", d_second, 32'h0000_0202);
      check("b2b_oe", oe0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
